// File: rtl/result_pipe.sv
// result_pipe: DEPTH-stage write-back shift pipeline with stall, flush and decode-port lookup.
// Optional forwarding is built when RESULT_PIPE_FWD_EN is defined; otherwise lookups raise hazard.
module result_pipe #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 3,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              flush,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              in_we,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_we,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic              fwd_hit_a,
  output logic [DATA_W-1:0] fwd_data_a,
  output logic              fwd_hit_b,
  output logic [DATA_W-1:0] fwd_data_b,
  output logic              hazard,
  output logic [CNT_W-1:0]  inflight
);

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DEPTH-1:0]  we_q;
  logic [CNT_W-1:0]  inflight_q;

  // NOTE: the stage array is small and the register file must never see stale
  // data after reset, so every stage is cleared, not just the valid bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        addr_q[i] <= '0;
      end
      we_q       <= '0;
      inflight_q <= '0;
    end else if (flush) begin
      // Data and address are left in place; only the write enables matter.
      we_q       <= '0;
      inflight_q <= '0;
    end else if (enable) begin
      data_q[0] <= in_data;
      addr_q[0] <= in_addr;
      we_q[0]   <= in_we;
      for (int i = 1; i < DEPTH; i++) begin
        data_q[i] <= data_q[i-1];
        addr_q[i] <= addr_q[i-1];
        we_q[i]   <= we_q[i-1];
      end
      inflight_q <= inflight_q + CNT_W'(in_we) - CNT_W'(we_q[DEPTH-1]);
    end
  end

  assign out_data = data_q[DEPTH-1];
  assign out_addr = addr_q[DEPTH-1];
  assign out_we   = we_q[DEPTH-1];
  assign inflight = inflight_q;

  // Lookups scan from oldest to youngest so the youngest match is written last.
  logic hit_a, hit_b;

`ifdef RESULT_PIPE_FWD_EN
  logic [DATA_W-1:0] win_a, win_b;

  // NOTE: every comb output gets a default before the loop, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
    win_a = '0;
    win_b = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (we_q[i] && addr_q[i] == rd_addr_a) begin
        hit_a = 1'b1;
        win_a = data_q[i];
      end
      if (we_q[i] && addr_q[i] == rd_addr_b) begin
        hit_b = 1'b1;
        win_b = data_q[i];
      end
    end
  end

  assign fwd_hit_a  = hit_a;
  assign fwd_data_a = win_a;
  assign fwd_hit_b  = hit_b;
  assign fwd_data_b = win_b;
  assign hazard     = 1'b0;
`else
  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (we_q[i] && addr_q[i] == rd_addr_a) hit_a = 1'b1;
      if (we_q[i] && addr_q[i] == rd_addr_b) hit_b = 1'b1;
    end
  end

  // Without forwarding, decode has to wait until the pending write retires.
  assign fwd_hit_a  = 1'b0;
  assign fwd_data_a = '0;
  assign fwd_hit_b  = 1'b0;
  assign fwd_data_b = '0;
  assign hazard     = hit_a | hit_b;
`endif

endmodule

// File: tb/tb_result_pipe.sv
// Directed bench for result_pipe: queue-based reference model checked every cycle,
// plus literal expectations from the hand-worked scenarios.
module tb_result_pipe;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 3;
  localparam int CNT_W  = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0;
  logic              flush = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic [ADDR_W-1:0] in_addr = '0;
  logic              in_we = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_we;
  logic [ADDR_W-1:0] rd_addr_a = '0;
  logic [ADDR_W-1:0] rd_addr_b = '0;
  logic              fwd_hit_a, fwd_hit_b, hazard;
  logic [DATA_W-1:0] fwd_data_a, fwd_data_b;
  logic [CNT_W-1:0]  inflight;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  result_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush),
    .in_data(in_data), .in_addr(in_addr), .in_we(in_we),
    .out_data(out_data), .out_addr(out_addr), .out_we(out_we),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .fwd_hit_a(fwd_hit_a), .fwd_data_a(fwd_data_a),
    .fwd_hit_b(fwd_hit_b), .fwd_data_b(fwd_data_b),
    .hazard(hazard), .inflight(inflight)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the youngest result sits at the front of a history queue.
  typedef struct {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic              we;
  } ent_t;

  ent_t hist[$];

  always @(posedge clk or negedge reset) begin
    if (!reset) hist.delete();
    else if (flush) begin
      foreach (hist[i]) hist[i].we = 1'b0;
    end else if (enable) begin
      hist.push_front('{in_data, in_addr, in_we});
      if (hist.size() > DEPTH) void'(hist.pop_back());
    end
  end

  function automatic int m_inflight();
    int n = 0;
    foreach (hist[i]) if (hist[i].we) n++;
    return n;
  endfunction

  function automatic logic m_hit(input logic [ADDR_W-1:0] a);
    foreach (hist[i]) if (hist[i].we && hist[i].addr == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [DATA_W-1:0] m_fwd(input logic [ADDR_W-1:0] a);
    foreach (hist[i]) if (hist[i].we && hist[i].addr == a) return hist[i].data;
    return '0;
  endfunction

  // Per-cycle comparison on the falling edge, away from state updates.
  always @(negedge clk) begin
    logic ow;
    ow = (hist.size() == DEPTH) ? hist[DEPTH-1].we : 1'b0;
    check("m_out_we", 32'(out_we), 32'(ow));
    if (ow) begin
      check("m_out_addr", 32'(out_addr), 32'(hist[DEPTH-1].addr));
      check("m_out_data", 32'(out_data), 32'(hist[DEPTH-1].data));
    end
    check("m_inflight", 32'(inflight), 32'(m_inflight()));
`ifdef RESULT_PIPE_FWD_EN
    check("m_hit_a", 32'(fwd_hit_a), 32'(m_hit(rd_addr_a)));
    check("m_hit_b", 32'(fwd_hit_b), 32'(m_hit(rd_addr_b)));
    check("m_data_a", 32'(fwd_data_a), 32'(m_fwd(rd_addr_a)));
    check("m_data_b", 32'(fwd_data_b), 32'(m_fwd(rd_addr_b)));
    check("m_hazard", 32'(hazard), 32'd0);
`else
    check("m_hit_a", 32'(fwd_hit_a), 32'd0);
    check("m_hit_b", 32'(fwd_hit_b), 32'd0);
    check("m_data_a", 32'(fwd_data_a), 32'd0);
    check("m_data_b", 32'(fwd_data_b), 32'd0);
    check("m_hazard", 32'(hazard), 32'(m_hit(rd_addr_a) | m_hit(rd_addr_b)));
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_we = 1'b0; flush = 1'b0; enable = 1'b1;
    repeat (DEPTH + 1) step();
  endtask

  initial begin
    #1 reset = 1'b0;
    #2;
    check("rst_out_we", 32'(out_we), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_inflight", 32'(inflight), 32'd0);
    check("rst_hazard", 32'(hazard), 32'd0);
    step(); step();
    reset = 1'b1;

    // Latency: single write, enable held high.
    enable = 1'b1; in_we = 1'b1; in_addr = 3'd5; in_data = 16'h1234;
    step(); in_we = 1'b0;
    check("lat_e0_infl", 32'(inflight), 32'd1);
    check("lat_e0_we", 32'(out_we), 32'd0);
    step();
    check("lat_e1_we", 32'(out_we), 32'd0);
    check("lat_e1_infl", 32'(inflight), 32'd1);
    step();
    check("lat_e2_we", 32'(out_we), 32'd1);
    check("lat_e2_addr", 32'(out_addr), 32'd5);
    check("lat_e2_data", 32'(out_data), 32'h1234);
    check("lat_e2_infl", 32'(inflight), 32'd1);
    step();
    check("lat_e3_we", 32'(out_we), 32'd0);
    check("lat_e3_infl", 32'(inflight), 32'd0);

    // Hold: two stalled cycles delay the output by two.
    in_we = 1'b1; in_addr = 3'd5; in_data = 16'h1234;
    step(); in_we = 1'b0; enable = 1'b0;
    step(); step();
    check("hold_e2_we", 32'(out_we), 32'd0);
    check("hold_e2_infl", 32'(inflight), 32'd1);
    enable = 1'b1;
    step();
    check("hold_e3_we", 32'(out_we), 32'd0);
    step();
    check("hold_e4_we", 32'(out_we), 32'd1);
    check("hold_e4_data", 32'(out_data), 32'h1234);
    step();
    check("hold_e5_we", 32'(out_we), 32'd0);

    // Same register written twice: the younger value must win.
    in_we = 1'b1; in_addr = 3'd3; in_data = 16'h00AA;
    step(); in_data = 16'h00BB;
    step(); in_we = 1'b0; enable = 1'b0;
    rd_addr_a = 3'd3; rd_addr_b = 3'd4;
    #1;
`ifdef RESULT_PIPE_FWD_EN
    check("fwd_hit_a", 32'(fwd_hit_a), 32'd1);
    check("fwd_data_a", 32'(fwd_data_a), 32'h00BB);
    check("fwd_hit_b", 32'(fwd_hit_b), 32'd0);
    check("fwd_data_b", 32'(fwd_data_b), 32'd0);
`else
    check("fwd_hazard", 32'(hazard), 32'd1);
    check("fwd_hit_a", 32'(fwd_hit_a), 32'd0);
`endif
    drain();

    // Flush with three writes in flight, flush beating enable and in_we.
    for (int i = 1; i <= 3; i++) begin
      in_we = 1'b1; in_addr = 3'(i); in_data = 16'(i * 16'h11);
      step();
    end
    check("fl_pre_infl", 32'(inflight), 32'd3);
    flush = 1'b1; in_addr = 3'd6; in_data = 16'hDEAD;
    step();
    flush = 1'b0; in_we = 1'b0; rd_addr_a = 3'd2; rd_addr_b = 3'd6;
    #1;
    check("fl_infl", 32'(inflight), 32'd0);
    check("fl_we", 32'(out_we), 32'd0);
    check("fl_hit_a", 32'(fwd_hit_a), 32'd0);
    check("fl_hazard", 32'(hazard), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      step();
      check("fl_drain_we", 32'(out_we), 32'd0);
    end

    // Async reset between edges clears everything without a clock.
    in_we = 1'b1; in_addr = 3'd4; in_data = 16'h4444;
    step(); in_addr = 3'd5; in_data = 16'h5555;
    step(); in_we = 1'b0; enable = 1'b0; rd_addr_a = 3'd4; rd_addr_b = 3'd5;
    check("ar_pre_infl", 32'(inflight), 32'd2);
    #2 reset = 1'b0;
    #1;
    check("ar_infl", 32'(inflight), 32'd0);
    check("ar_we", 32'(out_we), 32'd0);
    check("ar_data", 32'(out_data), 32'd0);
    check("ar_hit_a", 32'(fwd_hit_a), 32'd0);
    check("ar_data_b", 32'(fwd_data_b), 32'd0);
    check("ar_hazard", 32'(hazard), 32'd0);
    #3 reset = 1'b1;
    enable = 1'b1;

    // A pending write of r2 seen from read port B.
    in_we = 1'b1; in_addr = 3'd2; in_data = 16'h0077;
    step(); in_we = 1'b0; rd_addr_a = 3'd0; rd_addr_b = 3'd2;
    #1;
`ifdef RESULT_PIPE_FWD_EN
    check("r2_hit_b", 32'(fwd_hit_b), 32'd1);
    check("r2_data_b", 32'(fwd_data_b), 32'h0077);
    check("r2_hazard", 32'(hazard), 32'd0);
`else
    check("r2_hazard", 32'(hazard), 32'd1);
    check("r2_hit_b", 32'(fwd_hit_b), 32'd0);
`endif
    step(); step(); step();
    check("r2_ret_hazard", 32'(hazard), 32'd0);
    check("r2_ret_hit_b", 32'(fwd_hit_b), 32'd0);

    // Mixed traffic with stalls and flushes, checked by the model.
    for (int i = 0; i < 80; i++) begin
      enable    = ($urandom_range(3) != 0);
      flush     = ($urandom_range(9) == 0);
      in_we     = $urandom_range(1) == 1;
      in_addr   = 3'($urandom_range(7));
      in_data   = 16'($urandom);
      rd_addr_a = 3'($urandom_range(7));
      rd_addr_b = 3'($urandom_range(7));
      step();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
